// File: rtl/c2_accumulator_if.sv
// c2_accumulator_if: operand/result handshake bundle for c2_accumulator.
interface c2_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_data;
    logic             in_neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_data, in_neg, out_ready,
        output in_ready, out_valid, acc, ovf, op_count
    );

    modport master (
        output in_valid, in_data, in_neg, out_ready,
        input  in_ready, out_valid, acc, ovf, op_count
    );
endinterface

// File: rtl/c2_accumulator.sv
// c2_accumulator: signed accumulate of +/-operand with valid/ready result and sticky overflow.
// Define C2_ACC_SATURATE_EN to clamp acc on overflow instead of wrapping.
module c2_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    c2_accumulator_if.slave       bus
);
    typedef enum logic {ACCEPT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag, opnd, sum, upd;
    logic             ov;

    always_comb begin
        mag  = {{(WIDTH-5){1'b0}}, bus.in_data};
        opnd = bus.in_neg ? -mag : mag;
        sum  = acc_q + opnd;
        // overflow only possible when both addends share a sign
        ov   = (opnd[WIDTH-1] == acc_q[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
`ifdef C2_ACC_SATURATE_EN
        upd  = ov ? (acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : sum;
`else
        upd  = sum;
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ACCEPT;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ACCEPT && bus.in_valid) begin
            state_d = HOLD;
            acc_d   = upd;
            ovf_d   = ovf_q | ov;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = ACCEPT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCEPT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_c2_accumulator.sv
// tb_c2_accumulator: table-driven accumulate/overflow/clear vectors plus handshake corner sequences.
module tb_c2_accumulator;
    logic clk = 1'b0;
    logic rst_n, clr;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    c2_accumulator_if #(.WIDTH(8), .CNT_W(8)) bus ();

    c2_accumulator #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    typedef struct {
        logic       do_clr;
        logic [4:0] data;
        logic       neg;
        logic [7:0] exp_acc;
        logic       exp_ovf;
        logic [7:0] exp_cnt;
    } vec_t;

`ifdef C2_ACC_SATURATE_EN
    localparam logic [7:0] POS_OV = 8'h7F;
    localparam logic [7:0] NEG_OV = 8'h80;
    localparam logic [7:0] RAMP   = 8'h7F;
`else
    localparam logic [7:0] POS_OV = 8'h9B;
    localparam logic [7:0] NEG_OV = 8'h65;
    localparam logic [7:0] RAMP   = 8'h04;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] d, input logic n);
        chk("ready_before_op", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_neg   = n;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("out_valid_after_op", int'(bus.out_valid), 1);
    endtask

    task automatic op(input logic [4:0] d, input logic n);
        accept(d, n);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd7;
        bus.in_neg   = 1'b0;
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_out_valid", int'(bus.out_valid), 0);
        chk("clr_in_ready", int'(bus.in_ready), 1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{1'b0, 5'd5,  1'b0, 8'h05, 1'b0, 8'd1},
            '{1'b0, 5'd12, 1'b1, 8'hF9, 1'b0, 8'd2},
            '{1'b1, 5'd0,  1'b0, 8'h00, 1'b0, 8'd0},
            '{1'b0, 5'd31, 1'b0, 8'h1F, 1'b0, 8'd1},
            '{1'b0, 5'd31, 1'b0, 8'h3E, 1'b0, 8'd2},
            '{1'b0, 5'd31, 1'b0, 8'h5D, 1'b0, 8'd3},
            '{1'b0, 5'd31, 1'b0, 8'h7C, 1'b0, 8'd4},
            '{1'b0, 5'd31, 1'b0, POS_OV, 1'b1, 8'd5},
            '{1'b0, 5'd0,  1'b1, POS_OV, 1'b1, 8'd6},
            '{1'b1, 5'd0,  1'b0, 8'h00, 1'b0, 8'd0},
            '{1'b0, 5'd31, 1'b1, 8'hE1, 1'b0, 8'd1},
            '{1'b0, 5'd31, 1'b1, 8'hC2, 1'b0, 8'd2},
            '{1'b0, 5'd31, 1'b1, 8'hA3, 1'b0, 8'd3},
            '{1'b0, 5'd31, 1'b1, 8'h84, 1'b0, 8'd4},
            '{1'b0, 5'd31, 1'b1, NEG_OV, 1'b1, 8'd5},
            '{1'b0, 5'd0,  1'b1, NEG_OV, 1'b1, 8'd6},
            '{1'b1, 5'd0,  1'b0, 8'h00, 1'b0, 8'd0}
        };
        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 5'd9;
        bus.in_neg = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        chk("rst_acc", int'(bus.acc), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk("rst_cnt", int'(bus.op_count), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);

        foreach (vecs[i]) begin
            if (vecs[i].do_clr) do_clear();
            else op(vecs[i].data, vecs[i].neg);
            chk($sformatf("vec%0d_acc", i), int'(bus.acc), int'(vecs[i].exp_acc));
            chk($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_cnt", i), int'(bus.op_count), int'(vecs[i].exp_cnt));
        end

        // backpressure: result held while downstream stalls
        accept(5'd3, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data = 5'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_acc", int'(bus.acc), 8'h03);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        op(5'd9, 1'b0);
        chk("bp_acc_after", int'(bus.acc), 8'h0C);

        // clear while acc=0x20 in ACCEPT rejects the operand
        do_clear();
        op(5'd16, 1'b0);
        op(5'd16, 1'b0);
        chk("pre_clr_acc", int'(bus.acc), 8'h20);
        do_clear();
        chk("clr_acc", int'(bus.acc), 0);
        chk("clr_cnt", int'(bus.op_count), 0);
        chk("clr_ovf", int'(bus.ovf), 0);

        // clear in HOLD drops out_valid without handshake
        accept(5'd4, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("hold_clr_out_valid", int'(bus.out_valid), 0);
        chk("hold_clr_acc", int'(bus.acc), 0);

        // op_count saturates at 255 while acc keeps updating
        for (int k = 0; k < 260; k++) op(5'd1, 1'b0);
        chk("sat_cnt", int'(bus.op_count), 255);
        chk("sat_acc", int'(bus.acc), int'(RAMP));
        chk("sat_ovf", int'(bus.ovf), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
